// File: rtl/jtag_tap_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_master_ctrl
// Description : JTAG TAP master; walks the TAP for IR/DR scans and TAP reset,
//               returning captured TDO bits over a valid/ready command port.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_master_ctrl #(
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [$clog2(DATA_W+1)-1:0] cmd_len,
  input  logic [DATA_W-1:0]           cmd_data,
  output logic                        rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        rsp_err,
  output logic                        busy,
  output logic                        tck,
  output logic                        tms,
  output logic                        tdi,
  input  logic                        tdo
);

  localparam int c_len_w = $clog2(DATA_W+1);
  localparam int c_bit_w = (c_len_w > 3) ? c_len_w : 3;
  localparam int c_idx_w = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_len_w-1:0] c_len_max  = c_len_w'(DATA_W);
  localparam logic [1:0] c_op_ir  = 2'd1;
  localparam logic [1:0] c_op_rst = 2'd2;
  localparam logic [1:0] c_op_bad = 2'd3;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_PRE   = 3'd2,
    S_SHIFT = 3'd3,
    S_POST  = 3'd4,
    S_TAIL  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t               r_state, w_state_nxt, w_walk_nxt;
  logic [c_div_w-1:0]   r_div, w_div_nxt;
  logic                 r_high, w_high_nxt;
  logic [c_bit_w-1:0]   r_bit, w_bit_nxt, w_nbits;
  logic                 w_walk, w_tms, w_accept, w_illegal;
  logic [1:0]           r_op;
  logic [c_len_w-1:0]   r_len;
  logic [DATA_W-1:0]    r_data, r_cap, r_rsp_data;
  logic                 r_err, r_rsp_err;
  logic [c_idx_w-1:0]   w_idx;

  assign cmd_ready = (r_state == S_IDLE) || (r_state == S_DONE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign tck       = r_high;
  assign tms       = w_tms;
  assign w_idx     = r_bit[c_idx_w-1:0];
  assign tdi       = (r_state == S_SHIFT) ? r_data[w_idx] : 1'b0;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_illegal = (cmd_op == c_op_bad) || (cmd_len == '0) || (cmd_len > c_len_max);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_INIT;
      r_div   <= '0;
      r_high  <= 1'b0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_high  <= w_high_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  // Each walk state is a run of TCK periods; w_nbits/w_tms describe the path.
  always_comb begin
    w_state_nxt = r_state;
    w_walk_nxt  = r_state;
    w_div_nxt   = r_div;
    w_high_nxt  = r_high;
    w_bit_nxt   = r_bit;
    w_nbits     = '0;
    w_walk      = 1'b0;
    w_tms       = 1'b0;
    case (r_state)
      S_INIT: begin
        w_walk     = 1'b1;
        w_nbits    = c_bit_w'(6);
        w_tms      = (r_bit != c_bit_w'(5));
        w_walk_nxt = S_IDLE;
      end
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_nxt = w_illegal ? S_TAIL : S_PRE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PRE: begin
        w_walk = 1'b1;
        if (r_op == c_op_rst) begin
          w_nbits    = c_bit_w'(5);
          w_tms      = 1'b1;
          w_walk_nxt = S_POST;
        end else if (r_op == c_op_ir) begin
          w_nbits    = c_bit_w'(4);
          w_tms      = (r_bit < c_bit_w'(2));
          w_walk_nxt = S_SHIFT;
        end else begin
          w_nbits    = c_bit_w'(3);
          w_tms      = (r_bit == '0);
          w_walk_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_walk     = 1'b1;
        w_nbits    = c_bit_w'(r_len);
        w_tms      = (r_bit == w_nbits - 1'b1);
        w_walk_nxt = S_POST;
      end
      S_POST: begin
        w_walk     = 1'b1;
        w_nbits    = (r_op == c_op_rst) ? c_bit_w'(1) : c_bit_w'(2);
        w_tms      = (r_op != c_op_rst) && (r_bit == '0);
        w_walk_nxt = S_TAIL;
      end
      S_TAIL:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_INIT;
    endcase

    if (w_walk) begin
      if (r_div == c_div_last) begin
        w_div_nxt  = '0;
        w_high_nxt = ~r_high;
        if (r_high) begin
          if (r_bit == w_nbits - 1'b1) begin
            w_bit_nxt   = '0;
            w_state_nxt = w_walk_nxt;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end else begin
        w_div_nxt = r_div + 1'b1;
      end
    end
  end

  // Command latch, TDO capture on the TCK rising cycle, and response hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_op       <= '0;
      r_len      <= '0;
      r_data     <= '0;
      r_cap      <= '0;
      r_err      <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= cmd_op;
        r_len  <= cmd_len;
        r_data <= cmd_data;
        r_cap  <= '0;
        r_err  <= w_illegal;
      end
      if ((r_state == S_SHIFT) && !r_high && (r_div == c_div_last)) begin
        r_cap[w_idx] <= tdo;
      end
      if (r_state == S_TAIL) begin
        r_rsp_data <= r_cap;
        r_rsp_err  <= r_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_tap_master_ctrl
// Description : Bench for jtag_tap_master_ctrl with a behavioural TAP target.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_master_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [5:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy, tck, tms, tdi, tdo;

  always #5 clock = ~clock;

  jtag_tap_master_ctrl #(.DATA_W(32), .CLK_DIV(2)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  // Behavioural TAP target: 4-bit IR (capture 0x1), 32-bit DR.
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_t;

  tap_t        tap = TLR;
  logic [31:0] dr_cap = '0;
  logic [31:0] dr_sh = '0, dr_reg = '0;
  logic [3:0]  ir_sh = '0, ir_reg = '0;
  logic        tdo_t = 1'b0;
  logic        force1 = 1'b0;
  logic [63:0] tms_hist = '0;
  int          tck_cnt = 0, cyc = 0, rsp_cnt = 0;
  int          total = 0, bad = 0;

  assign tdo = force1 ? 1'b1 : tdo_t;

  function automatic tap_t tap_next(tap_t s, logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PA_DR;
      PA_DR:   return m ? EX2_DR : PA_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PA_IR;
      PA_IR:   return m ? EX2_IR : PA_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    case (tap)
      CAP_DR: dr_sh <= dr_cap;
      SH_DR:  dr_sh <= {tdi, dr_sh[31:1]};
      UPD_DR: dr_reg <= dr_sh;
      CAP_IR: ir_sh <= 4'h1;
      SH_IR:  ir_sh <= {tdi, ir_sh[3:1]};
      UPD_IR: ir_reg <= ir_sh;
      default: ;
    endcase
    tap <= tap_next(tap, tms);
    tms_hist = {tms_hist[62:0], tms};
    tck_cnt++;
  end

  always @(negedge tck)
    tdo_t <= (tap == SH_DR) ? dr_sh[0] : (tap == SH_IR) ? ir_sh[0] : 1'b0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected TMS path from the walk rules; returns edge count and bit pattern.
  function automatic logic [63:0] tms_path(input int op, input int len, output int n);
    logic [63:0] v = '0;
    n = 0;
    if (op == 2) begin
      for (int i = 0; i < 5; i++) begin v = {v[62:0], 1'b1}; n++; end
      v = {v[62:0], 1'b0}; n++;
    end else begin
      v = {v[62:0], 1'b1}; n++;
      if (op == 1) begin v = {v[62:0], 1'b1}; n++; end
      v = {v[62:0], 1'b0}; v = {v[62:0], 1'b0}; n += 2;
      for (int i = 0; i < len; i++) begin v = {v[62:0], (i == len - 1)}; n++; end
      v = {v[62:0], 1'b1}; v = {v[62:0], 1'b0}; n += 2;
    end
    return v;
  endfunction

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!cmd_ready && k < 1000) begin @(posedge clock); #1; k++; end
    if (!cmd_ready) chk({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic wait_rsp(input string tag);
    int k = 0;
    while (!rsp_valid && k < 2000) begin @(posedge clock); #1; k++; end
    if (!rsp_valid) chk({tag, "_rsp_timeout"}, 0, 1);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                         output logic [31:0] rsp, output logic err, output int lat, output int edges);
    int t0, e0;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
    wait_ready("cmd");
    e0 = tck_cnt;
    @(posedge clock); #1;
    t0 = cyc;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_len = 6'($urandom); cmd_data = $urandom;
    wait_rsp("cmd");
    lat = cyc - t0; edges = tck_cnt - e0; rsp = rsp_data; err = rsp_err;
  endtask

  initial begin
    logic [31:0] rsp, data, cap;
    logic [63:0] exp_path, mask;
    logic        err;
    int          lat, edges, n, e0, t0, rc;
    logic [5:0]  len;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 1);
    chk("rst_tck", tck, 0);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);

    // INIT walk
    @(negedge clock); reset = 1'b1; e0 = tck_cnt;
    wait_ready("init");
    chk("init_edges", tck_cnt - e0, 6);
    chk("init_tms", tms_hist[5:0], 6'b111110);
    chk("init_tap_rti", tap, RTI);
    chk("idle_busy", busy, 0);
    chk("idle_tck_tms", {tck, tms}, 0);

    // IR scan, len 4
    run_cmd(2'd1, 6'd4, 32'hA, rsp, err, lat, edges);
    chk("ir_edges", edges, 10);
    chk("ir_reg", ir_reg, 4'hA);
    chk("ir_rsp", rsp, 32'h1);
    chk("ir_err", err, 0);
    chk("ir_lat", lat, 41);
    exp_path = tms_path(1, 4, n);
    chk("ir_tms_path", tms_hist[9:0], exp_path[9:0]);

    // DR scan, len 32
    dr_cap = 32'h12345678;
    run_cmd(2'd0, 6'd32, 32'hDEADBEEF, rsp, err, lat, edges);
    chk("dr32_edges", edges, 37);
    chk("dr32_reg", dr_reg, 32'hDEADBEEF);
    chk("dr32_rsp", rsp, 32'h12345678);
    chk("dr32_lat", lat, 149);
    exp_path = tms_path(0, 32, n);
    mask = (64'd1 << n) - 1;
    chk("dr32_tms_path", tms_hist & mask, exp_path & mask);
    repeat (5) @(posedge clock);
    #1;
    chk("rsp_hold", rsp_data, 32'h12345678);

    // Illegal commands
    run_cmd(2'd0, 6'd0, 32'hFFFF_FFFF, rsp, err, lat, edges);
    chk("len0_err_rsp", {err, rsp}, {1'b1, 32'h0});
    chk("len0_lat_edges", {lat[15:0], edges[15:0]}, {16'd1, 16'd0});
    run_cmd(2'd3, 6'd8, 32'hFFFF_FFFF, rsp, err, lat, edges);
    chk("op3_err_rsp", {err, rsp}, {1'b1, 32'h0});
    chk("op3_lat_edges", {lat[15:0], edges[15:0]}, {16'd1, 16'd0});
    run_cmd(2'd0, 6'd33, 32'hFFFF_FFFF, rsp, err, lat, edges);
    chk("len33_err_rsp", {err, rsp}, {1'b1, 32'h0});
    chk("len33_lat_edges", {lat[15:0], edges[15:0]}, {16'd1, 16'd0});

    // TAP reset command
    run_cmd(2'd2, 6'd1, 32'h0, rsp, err, lat, edges);
    chk("trst_edges", edges, 6);
    chk("trst_err_rsp", {err, rsp}, 33'h0);
    chk("trst_lat", lat, 25);
    chk("trst_tap_rti", tap, RTI);
    exp_path = tms_path(2, 0, n);
    chk("trst_tms_path", tms_hist[5:0], exp_path[5:0]);

    // Random DR scans checked against shift arithmetic
    for (int i = 0; i < 6; i++) begin
      len = 6'($urandom_range(1, 32)); data = $urandom; cap = $urandom;
      dr_cap = cap;
      run_cmd(2'd0, len, data, rsp, err, lat, edges);
      mask = (64'd1 << len) - 1;
      chk("rnd_dr_rsp", rsp, cap & mask[31:0]);
      chk("rnd_dr_reg", dr_reg, 32'({data, cap} >> len));
      chk("rnd_dr_edges_lat", {edges[15:0], lat[15:0]}, {16'(len + 5), 16'(4 * (len + 5) + 1)});
      chk("rnd_dr_err", err, 0);
    end
    for (int i = 0; i < 3; i++) begin
      data = 32'($urandom_range(0, 15));
      run_cmd(2'd1, 6'd4, data, rsp, err, lat, edges);
      chk("rnd_ir_reg", ir_reg, data[3:0]);
      chk("rnd_ir_rsp", rsp, 32'h1);
    end

    // Reset during SHIFT bit 10 of a 32-bit DR scan
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_len = 6'd32; cmd_data = $urandom;
    wait_ready("abort");
    @(posedge clock); #1;
    cmd_valid = 1'b0; e0 = tck_cnt; rc = rsp_cnt;
    n = 0;
    while ((tck_cnt - e0) < 14 && n < 1000) begin @(posedge clock); #1; n++; end
    chk("abort_reached_bit10", tck_cnt - e0, 14);
    #2 reset = 1'b0;
    #1;
    chk("abort_tck_tms", {tck, tms}, 2'b01);
    chk("abort_ready_busy", {cmd_ready, busy}, 2'b01);
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b1; e0 = tck_cnt;
    wait_ready("reinit");
    chk("reinit_edges", tck_cnt - e0, 6);
    chk("reinit_tms", tms_hist[5:0], 6'b111110);
    chk("reinit_tap_rti", tap, RTI);
    chk("abort_no_rsp", rsp_cnt, rc);
    run_cmd(2'd1, 6'd4, 32'h5, rsp, err, lat, edges);
    chk("post_abort_ir", {ir_reg, rsp[3:0], err}, {4'h5, 4'h1, 1'b0});

    // Back-to-back with cmd_valid held, tdo tied high
    force1 = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_len = 6'd8; cmd_data = $urandom;
    wait_ready("b2b");
    @(posedge clock); #1;
    t0 = cyc;
    wait_rsp("b2b1");
    chk("b2b1_lat", cyc - t0, 53);
    chk("b2b1_rsp", rsp_data, 32'h0000_00FF);
    chk("b2b1_ready_in_done", cmd_ready, 1);
    @(posedge clock); #1;
    t0 = cyc;
    cmd_valid = 1'b0;
    chk("b2b2_accepted", busy, 1);
    wait_rsp("b2b2");
    chk("b2b2_lat", cyc - t0, 53);
    chk("b2b2_rsp", rsp_data, 32'h0000_00FF);
    force1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
